// File: rtl/audio_gain_router_pkg.sv
`default_nettype none
// ============================================================================
// Package     : audio_pkg
// Description : Shared FSM encoding, saturation helper and unity-gain constant
//               for the audio_gain_router sample path.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package audio_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_SWITCH    = 2'd2,
    ST_RAMP_UP   = 2'd3
  } state_t;

  localparam int C_SAT_W = 64;

  function automatic int unity_gain(input int frac);
    return 1 << frac;
  endfunction

  // Clamp a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [C_SAT_W-1:0] saturate(
    input logic signed [C_SAT_W-1:0] v,
    input int                        w
  );
    logic signed [C_SAT_W-1:0] hi;
    logic signed [C_SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_gain_router_lane.sv
`default_nettype none
// ============================================================================
// Module      : audio_gain_lane
// Description : One channel of the gain path: product register, shift (with
//               optional round-half-up under AUDIO_GAIN_ROUND_EN), saturation,
//               sticky clip flag and dac_valid strobe. Two-cycle latency.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module audio_gain_lane
  import audio_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [GAIN_W-1:0] i_gain,
  input  logic              i_clip_clr,
  output logic [DATA_W-1:0] o_dac,
  output logic              o_valid,
  output logic              o_clip
);

  localparam int C_PROD_W = DATA_W + GAIN_W + 1;

  logic signed [C_PROD_W-1:0] w_a;
  logic signed [C_PROD_W-1:0] w_b;
  logic signed [C_PROD_W-1:0] w_mult;
  logic signed [C_PROD_W-1:0] w_biased;
  logic signed [C_PROD_W-1:0] w_shift;
  logic signed [C_SAT_W-1:0]  w_wide;
  logic signed [C_SAT_W-1:0]  w_sat;
  logic                       w_clip;

  logic signed [C_PROD_W-1:0] r_prod;
  logic                       r_req_d;
  logic [DATA_W-1:0]          r_dac;
  logic                       r_valid;
  logic                       r_clip;

  // Gain is unsigned: zero-extend it so the signed multiply treats it as positive.
  assign w_a    = {{(GAIN_W+1){i_sample[DATA_W-1]}}, i_sample};
  assign w_b    = {{DATA_W{1'b0}}, 1'b0, i_gain};
  assign w_mult = w_a * w_b;

`ifdef AUDIO_GAIN_ROUND_EN
  localparam logic signed [C_PROD_W-1:0] C_HALF =
    {{(C_PROD_W-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);
  assign w_biased = r_prod + C_HALF;
`else
  assign w_biased = r_prod;
`endif

  assign w_shift = w_biased >>> GAIN_FRAC;
  assign w_wide  = {{(C_SAT_W-C_PROD_W){w_shift[C_PROD_W-1]}}, w_shift};
  assign w_sat   = saturate(w_wide, DATA_W);
  assign w_clip  = (w_sat != w_wide);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_req_d <= 1'b0;
      r_dac   <= '0;
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_req_d <= i_req;
      r_valid <= r_req_d;
      if (i_req) begin
        r_prod <= w_mult;
      end
      if (r_req_d) begin
        r_dac <= w_sat[DATA_W-1:0];
      end
      // A new saturation outranks a simultaneous clear.
      if (r_req_d && w_clip) begin
        r_clip <= 1'b1;
      end else if (i_clip_clr) begin
        r_clip <= 1'b0;
      end
    end
  end

  assign o_dac   = r_dac;
  assign o_valid = r_valid;
  assign o_clip  = r_clip;

endmodule
`default_nettype wire

// File: rtl/audio_gain_router.sv
`default_nettype none
// ============================================================================
// Module      : audio_gain_router
// Description : Per-channel DAC source select with click-free ramped gain and
//               source switching, plus unscaled ADC record capture.
//               Optional rounding: define AUDIO_GAIN_ROUND_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module audio_gain_router
  import audio_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4,
  parameter int RAMP_STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        sample_req,
  input  logic [NUM_CH-1:0]        sample_end,
  input  logic [NUM_CH*DATA_W-1:0] adc_in,
  input  logic [NUM_CH*DATA_W-1:0] play_in,
  input  logic                     playback,
  input  logic [GAIN_W-1:0]        gain,
  input  logic                     clip_clr,
  output logic [NUM_CH*DATA_W-1:0] dac_out,
  output logic [NUM_CH-1:0]        dac_valid,
  output logic [NUM_CH*DATA_W-1:0] rec_out,
  output logic [NUM_CH-1:0]        rec_valid,
  output logic [NUM_CH-1:0]        clip,
  output logic                     busy,
  output logic                     src_sel
);

  localparam logic [GAIN_W-1:0] C_STEP = GAIN_W'(RAMP_STEP);

  state_t            r_state;
  logic [GAIN_W-1:0] r_cur_gain;
  logic              r_src_sel;
  logic              r_busy;

  logic              w_tick;
  logic [GAIN_W-1:0] w_target;
  logic [GAIN_W-1:0] w_diff;
  logic [GAIN_W-1:0] w_next_gain;

  assign w_tick = sample_req[0];

  // Step toward the target by at most C_STEP, never past it.
  always_comb begin
    w_target    = (r_state == ST_RAMP_DOWN || r_state == ST_SWITCH) ? '0 : gain;
    w_diff      = '0;
    w_next_gain = r_cur_gain;
    if (r_cur_gain < w_target) begin
      w_diff      = w_target - r_cur_gain;
      w_next_gain = r_cur_gain + ((w_diff > C_STEP) ? C_STEP : w_diff);
    end else if (r_cur_gain > w_target) begin
      w_diff      = r_cur_gain - w_target;
      w_next_gain = r_cur_gain - ((w_diff > C_STEP) ? C_STEP : w_diff);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_cur_gain <= '0;
      r_src_sel  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cur_gain <= w_next_gain;
      end
      case (r_state)
        ST_RUN: begin
          if (playback != r_src_sel) begin
            r_state <= ST_RAMP_DOWN;
            r_busy  <= 1'b1;
          end
        end
        ST_RAMP_DOWN: begin
          if (r_cur_gain == '0) begin
            r_state <= ST_SWITCH;
          end
        end
        // Whatever playback reads at this tick wins, even if it equals the old source.
        ST_SWITCH: begin
          if (w_tick) begin
            r_src_sel <= playback;
            r_state   <= ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          if (r_cur_gain == gain) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign src_sel = r_src_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] w_sample;
    logic [DATA_W-1:0] r_rec;
    logic              r_rec_valid;

    assign w_sample = r_src_sel ? play_in[i*DATA_W +: DATA_W] : adc_in[i*DATA_W +: DATA_W];

    audio_gain_lane #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_lane (
      .clk        (clk),
      .rst        (reset),
      .i_req      (sample_req[i]),
      .i_sample   (w_sample),
      .i_gain     (r_cur_gain),
      .i_clip_clr (clip_clr),
      .o_dac      (dac_out[i*DATA_W +: DATA_W]),
      .o_valid    (dac_valid[i]),
      .o_clip     (clip[i])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rec       <= '0;
        r_rec_valid <= 1'b0;
      end else begin
        r_rec_valid <= sample_end[i];
        if (sample_end[i]) begin
          r_rec <= adc_in[i*DATA_W +: DATA_W];
        end
      end
    end

    assign rec_out[i*DATA_W +: DATA_W] = r_rec;
    assign rec_valid[i]                = r_rec_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_gain_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_gain_router
// Description : Self-checking bench: scoreboard of expected DAC samples from a
//               behavioural ramp/FSM model, vector table and corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_gain_router;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int GW = 8;
  localparam int GF = 4;

`ifdef AUDIO_GAIN_ROUND_EN
  localparam logic [15:0] E_HALF_P = 16'h0002;
  localparam logic [15:0] E_HALF_N = 16'hFFFF;
  localparam logic [15:0] E_ONE_P5 = 16'h0002;
`else
  localparam logic [15:0] E_HALF_P = 16'h0001;
  localparam logic [15:0] E_HALF_N = 16'hFFFE;
  localparam logic [15:0] E_ONE_P5 = 16'h0001;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NC-1:0]     sample_req = '0;
  logic [NC-1:0]     sample_end = '0;
  logic [NC*DW-1:0]  adc_in = '0;
  logic [NC*DW-1:0]  play_in = '0;
  logic              playback = 1'b0;
  logic [GW-1:0]     gain = '0;
  logic              clip_clr = 1'b0;
  logic [NC*DW-1:0]  dac_out;
  logic [NC-1:0]     dac_valid;
  logic [NC*DW-1:0]  rec_out;
  logic [NC-1:0]     rec_valid;
  logic [NC-1:0]     clip;
  logic              busy;
  logic              src_sel;

  always #5 clk = ~clk;

  audio_gain_router dut (
    .clk        (clk),
    .reset      (reset),
    .sample_req (sample_req),
    .sample_end (sample_end),
    .adc_in     (adc_in),
    .play_in    (play_in),
    .playback   (playback),
    .gain       (gain),
    .clip_clr   (clip_clr),
    .dac_out    (dac_out),
    .dac_valid  (dac_valid),
    .rec_out    (rec_out),
    .rec_valid  (rec_valid),
    .clip       (clip),
    .busy       (busy),
    .src_sel    (src_sel)
  );

  typedef struct {
    int          lane;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  g;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  cl;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_cur = 0;
  int   m_state = 0;
  logic m_src = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_dac(input logic [15:0] s, input int g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
`ifdef AUDIO_GAIN_ROUND_EN
    p = p + 8;
`endif
    p = p >>> GF;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  task automatic model_reset();
    m_cur   = 0;
    m_state = 0;
    m_src   = 1'b0;
    sbq.delete();
  endtask

  // Behavioural ramp/source-switch model evaluated with pre-edge values.
  task automatic model_step(input logic tick);
    int tgt;
    int nxt;
    tgt = (m_state == 1 || m_state == 2) ? 0 : int'(gain);
    nxt = m_cur;
    if (tick) begin
      if (m_cur < tgt)      nxt = m_cur + 1;
      else if (m_cur > tgt) nxt = m_cur - 1;
    end
    case (m_state)
      0: if (playback != m_src) m_state = 1;
      1: if (m_cur == 0) m_state = 2;
      2: if (tick) begin m_src = playback; m_state = 3; end
      default: if (m_cur == int'(gain)) m_state = 0;
    endcase
    m_cur = nxt;
  endtask

  task automatic check_cycle(input logic [1:0] send);
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      if (dac_valid[i]) begin
        if (sbq.size() == 0 || sbq[0].lane != i) begin
          n_checks++;
          n_errors++;
          $display("FAIL dac_valid lane%0d: got unexpected strobe, expected none", i);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("dac_out lane%0d", i), 32'(dac_out[i*DW +: DW]), 32'(e.val));
          chk("dac latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
    while (sbq.size() > 0 && sbq[0].cyc + 2 <= cyc) begin
      e = sbq.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL dac_valid lane%0d: got no strobe, expected %0h", e.lane, e.val);
    end
    chk("rec_valid", 32'(rec_valid), 32'(send));
    for (int i = 0; i < NC; i++) begin
      if (send[i]) chk($sformatf("rec_out lane%0d", i), 32'(rec_out[i*DW +: DW]), 32'(adc_in[i*DW +: DW]));
    end
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("src_sel", 32'(src_sel), 32'(m_src));
  endtask

  task automatic cycle(input logic [1:0] req, input logic [1:0] send, input logic clr);
    exp_t e;
    sample_req = req;
    sample_end = send;
    clip_clr   = clr;
    for (int i = 0; i < NC; i++) begin
      if (req[i]) begin
        e.lane = i;
        e.val  = exp_dac(m_src ? play_in[i*DW +: DW] : adc_in[i*DW +: DW], m_cur);
        e.cyc  = cyc;
        sbq.push_back(e);
      end
    end
    model_step(req[0]);
    @(negedge clk);
    cyc++;
    check_cycle(send);
    sample_req = '0;
    sample_end = '0;
    clip_clr   = 1'b0;
  endtask

  task automatic frame();
    cycle(2'b11, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
  endtask

  task automatic do_reset_async();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("reset dac_out", dac_out, 32'h0);
    chk("reset dac_valid", 32'(dac_valid), 32'h0);
    chk("reset rec_out", rec_out, 32'h0);
    chk("reset rec_valid", 32'(rec_valid), 32'h0);
    chk("reset clip", 32'(clip), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset src_sel", 32'(src_sel), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   n;
    logic saw_zero;

    tbl[0] = '{8'd16,  16'h1000, 16'hF000, 16'h1000, 16'hF000, 2'b00};
    tbl[1] = '{8'd64,  16'h4000, 16'hC000, 16'h7FFF, 16'h8000, 2'b11};
    tbl[2] = '{8'd8,   16'h0003, 16'hFFFD, E_HALF_P, E_HALF_N, 2'b00};
    tbl[3] = '{8'd255, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 2'b11};
    tbl[4] = '{8'd0,   16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 2'b00};
    tbl[5] = '{8'd24,  16'h0001, 16'h0010, E_ONE_P5, 16'h0018, 2'b00};
    tbl[6] = '{8'd20,  16'h8000, 16'h0100, 16'h8000, 16'h0140, 2'b01};

    // Soft start from reset
    gain    = 8'd16;
    adc_in  = {16'h1000, 16'h1000};
    play_in = {16'h0800, 16'h0800};
    @(negedge clk);
    do_reset_async();
    for (int f = 1; f <= 20; f++) begin
      frame();
      if (f == 2) chk("soft start frame2", 32'(dac_out[15:0]), 32'h0100);
    end
    chk("soft start final", dac_out, {16'h1000, 16'h1000});
    chk("soft start busy", 32'(busy), 32'h0);
    cycle(2'b11, 2'b00, 1'b0);
    cycle(2'b11, 2'b00, 1'b0);
    cycle(2'b10, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);

    // Steady-state datapath vectors
    foreach (tbl[v]) begin
      gain   = tbl[v].g;
      adc_in = {tbl[v].a1, tbl[v].a0};
      n = 0;
      while (m_cur != int'(gain) && n < 300) begin
        frame();
        n++;
      end
      cycle(2'b00, 2'b00, 1'b1);
      frame();
      chk($sformatf("vec%0d lane0", v), 32'(dac_out[15:0]), 32'(tbl[v].e0));
      chk($sformatf("vec%0d lane1", v), 32'(dac_out[31:16]), 32'(tbl[v].e1));
      chk($sformatf("vec%0d clip", v), 32'(clip), 32'(tbl[v].cl));
    end

    // Clear coinciding with a fresh saturation keeps the flag
    cycle(2'b00, 2'b00, 1'b1);
    chk("clip cleared", 32'(clip), 32'h0);
    cycle(2'b11, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b1);
    chk("clip set wins", 32'(clip), 32'h1);
    cycle(2'b00, 2'b00, 1'b1);
    chk("clip clear", 32'(clip), 32'h0);

    // Record path
    adc_in = {16'h1234, 16'h5555};
    cycle(2'b00, 2'b10, 1'b0);
    chk("rec_valid pulse", 32'(rec_valid), 32'h2);
    chk("rec_out lane1", 32'(rec_out[31:16]), 32'h1234);
    cycle(2'b00, 2'b00, 1'b0);
    chk("rec_out hold", 32'(rec_out[31:16]), 32'h1234);

    // Source switch adc -> playback
    gain   = 8'd16;
    adc_in = {16'h1000, 16'h1000};
    n = 0;
    while (m_cur != 16 && n < 300) begin
      frame();
      n++;
    end
    playback = 1'b1;
    cycle(2'b00, 2'b00, 1'b0);
    chk("switch busy start", 32'(busy), 32'h1);
    for (int f = 1; f <= 16; f++) begin
      frame();
      if (f == 5) cycle(2'b00, 2'b01, 1'b0);
    end
    chk("ramp down last", 32'(dac_out[15:0]), 32'h0100);
    chk("src before switch", 32'(src_sel), 32'h0);
    frame();
    chk("src after switch", 32'(src_sel), 32'h1);
    chk("busy in ramp up", 32'(busy), 32'h1);
    for (int f = 18; f <= 32; f++) frame();
    chk("busy late ramp up", 32'(busy), 32'h1);
    frame();
    chk("busy back to run", 32'(busy), 32'h0);
    frame();
    chk("playback level", dac_out, {16'h0800, 16'h0800});

    // Toggle mid ramp-down: mute dip only
    playback = 1'b0;
    for (int f = 0; f < 3; f++) frame();
    playback = 1'b1;
    saw_zero = 1'b0;
    n = 0;
    while (m_state != 0 && n < 80) begin
      frame();
      if (dac_out[15:0] == 16'h0000) saw_zero = 1'b1;
      n++;
    end
    frame();
    chk("dip reached zero", 32'(saw_zero), 32'h1);
    chk("dip src kept", 32'(src_sel), 32'h1);
    chk("dip recovery", 32'(dac_out[15:0]), 32'h0800);

    // Reset during ramp up
    playback = 1'b0;
    n = 0;
    while (m_state != 3 && n < 80) begin
      frame();
      n++;
    end
    for (int f = 0; f < 5; f++) frame();
    chk("busy before reset", 32'(busy), 32'h1);
    do_reset_async();
    frame();
    frame();
    chk("restart frame2", 32'(dac_out[15:0]), 32'h0100);
    chk("restart src", 32'(src_sel), 32'h0);
    cycle(2'b00, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_gain_router.md
Name: audio_gain_router

Overview:
- Parametrised successor to the fixed 16-bit, single-gain codec sample path.
- Per channel:
  - selects the DAC source (live ADC or playback memory);
  - applies a signed, saturating fractional gain;
  - returns recorded ADC samples with a valid strobe.
- Gain changes and source switches ramp one step per audio frame, so there are no clicks or zipper noise.
- Sits between audio_codec (sample_req/sample_end, parallel samples) and the recorder memory/controller, in the audio_clk domain.

Parameters:
- DATA_W, 16, sample width (two's complement)
- NUM_CH, 2, channel count; channel i occupies bits [i*DATA_W +: DATA_W]
- GAIN_W, 8, unsigned gain width
- GAIN_FRAC, 4, fractional bits of gain (default: 16 = unity, max 15.9375)
- RAMP_STEP, 1, gain LSBs moved per frame tick

Ports:
- clk  in  1  audio clock
- reset  in  1  asynchronous, active-high
- sample_req  in  NUM_CH  codec requests next DAC sample (1-cycle pulse per channel)
- sample_end  in  NUM_CH  codec ADC sample complete (1-cycle pulse per channel)
- adc_in  in  NUM_CH*DATA_W  deserialised ADC samples
- play_in  in  NUM_CH*DATA_W  playback samples from memory
- playback  in  1  requested source: 1 = play_in, 0 = adc_in
- gain  in  GAIN_W  target gain
- clip_clr  in  1  clears clip flags
- dac_out  out  NUM_CH*DATA_W  scaled samples to codec
- dac_valid  out  NUM_CH  1-cycle strobe with dac_out
- rec_out  out  NUM_CH*DATA_W  captured ADC samples to recorder
- rec_valid  out  NUM_CH  1-cycle strobe with rec_out
- clip  out  NUM_CH  sticky saturation flags
- busy  out  1  high while not in RUN
- src_sel  out  1  source currently in effect

Behaviour:
- Reset values:
  - all outputs 0;
  - internal cur_gain = 0, state = RUN, src_sel = 0.
  - After reset the gain soft-starts from 0 toward gain.
- Frame tick is sample_req[0].
- cur_gain update on each tick:
  - moves toward the state target by min(RAMP_STEP, |target-cur_gain|);
  - never overshoots;
  - is unchanged between ticks.
- FSM states RUN, RAMP_DOWN, SWITCH, RAMP_UP:
  - RUN: target = gain. If playback != src_sel → RAMP_DOWN. A change on gain alone just ramps, with no state change.
  - RAMP_DOWN: target = 0. When cur_gain == 0 → SWITCH.
  - SWITCH: on the next tick, src_sel <= current playback, then → RAMP_UP.
  - RAMP_UP: target = gain. When cur_gain == gain → RUN.
- Toggling playback during RAMP_DOWN/SWITCH does not abort the sequence. The value sampled at SWITCH wins. If that value equals the old src_sel, the result is a mute dip only.
- If playback changes again during RAMP_UP, RUN detects the mismatch and restarts the sequence.
- Datapath per channel, 2-cycle latency:
  - Cycle after sample_req[i]: register the signed product of the selected sample and {1'b0, cur_gain}, width DATA_W+GAIN_W+1.
  - Next cycle: arithmetic shift right by GAIN_FRAC (truncation toward -inf), saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], drive dac_out[i], pulse dac_valid[i].
  - The pipeline accepts back-to-back sample_req; each channel is independent.
- dac_out holds between strobes.
- clip[i] is set in the saturation cycle. clip_clr clears it; if clear and set coincide, set wins.
- Recording path:
  - sample_end[i] → next cycle rec_out[i] <= adc_in[i] (unscaled), rec_valid[i] pulses.
  - Independent of src_sel and of the FSM.
- Reset mid-ramp returns everything to reset values immediately.

Optional Feature:
- Macro AUDIO_GAIN_ROUND_EN.
- Defined: add 2^(GAIN_FRAC-1) to the product before the shift (round half up), then saturate.
- Undefined: plain truncation.
- Latency is unchanged in both cases.

Decomposition:
- Package audio_pkg holds:
  - FSM state encoding (RUN=0, RAMP_DOWN=1, SWITCH=2, RAMP_UP=3);
  - the saturate function;
  - the unity-gain constant (1 << GAIN_FRAC).
- One sub-module, audio_gain_lane: product register, shift/round, saturation, clip flag and dac_valid for a single channel.
- audio_gain_lane is instantiated NUM_CH times via generate.
- The top level holds the FSM, cur_gain ramp and record capture.

Test Plan:
- Soft start: reset then release, gain=16, adc_in=0x1000, 20 ticks. Expected:
  - dac_out ramps 0x0000, 0x0100, … 0x1000 by tick 16 and stays there;
  - dac_valid appears 2 cycles after each sample_req; busy stays 0.
- Saturation: gain=64 (4.0), steady state, adc_in ch0=0x4000, ch1=0xC000 → dac_out 0x7FFF / 0x8000, clip=2'b11. clip_clr in the same cycle as a new clip leaves clip set.
- Source switch: playback 0→1 with gain=16, adc_in=0x1000, play_in=0x0800. Expected:
  - 16 ticks ramping down to 0, SWITCH, src_sel=1;
  - 16 ticks ramping up to 0x0800; busy high throughout.
- Toggle mid-ramp: playback 0→1→0 during RAMP_DOWN → dip to 0, src_sel stays 0, recovery to 0x1000.
- Record path: sample_end[1] with adc_in ch1=0x1234 → rec_out ch1=0x1234 and rec_valid=2'b10 one cycle later, regardless of playback/state.
- Reset mid-operation: assert reset at RAMP_UP tick 5 → all outputs 0 asynchronously, then soft start from 0. With AUDIO_GAIN_ROUND_EN, gain=24 (1.5) and sample 0x0001 → 0x0002 (0x0001 without the macro).
